// File: rtl/iwm_write_serializer.sv
// IWM write-side serializer: buffers CPU data-register writes and shifts them
// MSB-first onto the write stream as level transitions, one cell per BIT_CELL_CLKS cen ticks.
module iwm_write_serializer #(
   parameter int BIT_CELL_CLKS = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cen,
   input  logic       wrMode,
   input  logic       dataWr,
   input  logic [7:0] dataIn,
   output logic       bufEmpty,
   output logic       writeUnderrun_n,
   output logic       wrStream,
   output logic       byteDone,
   output logic [7:0] byteOut
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      UNDERRUN
   } state_t;

   localparam logic [7:0] CELL_LAST = 8'(BIT_CELL_CLKS - 1);

   state_t     state_q, state_d;
   logic [7:0] buf_q, buf_d;
   logic       full_q, full_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] timer_q, timer_d;
   logic       ws_q, ws_d;
   logic       une_q, une_d;
   logic       done_q, done_d;
   logic [7:0] out_q, out_d;

   logic       wr_acc;
   logic       load;
   logic [7:0] load_byte;

   always_comb begin
      state_d   = state_q;
      buf_d     = buf_q;
      full_d    = full_q;
      shift_d   = shift_q;
      idx_d     = idx_q;
      timer_d   = timer_q;
      ws_d      = ws_q;
      une_d     = une_q;
      done_d    = 1'b0;
      out_d     = out_q;
      wr_acc    = 1'b0;
      load      = 1'b0;
      load_byte = buf_q;
      if (!wrMode) begin
         // Abort: partial byte is dropped, stream level is left as it was.
         state_d = IDLE;
         full_d  = 1'b0;
         une_d   = 1'b1;
      end else begin
         wr_acc = dataWr && !full_q && (state_q != UNDERRUN);
         if (wr_acc) begin
            buf_d  = dataIn;
            full_d = 1'b1;
         end
         if (cen) begin
            unique case (state_q)
               IDLE: begin
                  if (full_q) begin
                     load      = 1'b1;
                     load_byte = buf_q;
                  end
               end
               SHIFT: begin
                  if (timer_q != 8'd0) begin
                     timer_d = timer_q - 8'd1;
                  end else if (idx_q != 3'd0) begin
                     timer_d = CELL_LAST;
                     idx_d   = idx_q - 3'd1;
                     if (shift_q[idx_q - 3'd1]) ws_d = ~ws_q;
                  end else begin
                     done_d = 1'b1;
                     out_d  = shift_q;
                     // A write landing on the boundary cycle feeds the shifter directly.
                     if (full_q) begin
                        load      = 1'b1;
                        load_byte = buf_q;
                     end else if (wr_acc) begin
                        load      = 1'b1;
                        load_byte = dataIn;
                     end else begin
                        state_d = UNDERRUN;
                        une_d   = 1'b0;
                     end
                  end
               end
               default: ;
            endcase
         end
         if (load) begin
            shift_d = load_byte;
            idx_d   = 3'd7;
            timer_d = CELL_LAST;
            full_d  = 1'b0;
            state_d = SHIFT;
            if (load_byte[7]) ws_d = ~ws_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         buf_q   <= 8'd0;
         full_q  <= 1'b0;
         shift_q <= 8'd0;
         idx_q   <= 3'd0;
         timer_q <= 8'd0;
         ws_q    <= 1'b0;
         une_q   <= 1'b1;
         done_q  <= 1'b0;
         out_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         full_q  <= full_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         timer_q <= timer_d;
         ws_q    <= ws_d;
         une_q   <= une_d;
         done_q  <= done_d;
         out_q   <= out_d;
      end
   end

   assign bufEmpty        = ~full_q;
   assign writeUnderrun_n = une_q;
   assign wrStream        = ws_q;
   assign byteDone        = done_q;
   assign byteOut         = out_q;

endmodule

// File: tb/tb_iwm_write_serializer.sv
// Bench for iwm_write_serializer: directed table, hand sequences and a
// randomized run compared each cycle against a byte-timeline model.
module tb_iwm_write_serializer;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       reset, cen, wrMode, dataWr;
   logic [7:0] dataIn;
   logic       bufEmpty, writeUnderrun_n, wrStream, byteDone;
   logic [7:0] byteOut;

   iwm_write_serializer #(.BIT_CELL_CLKS(N)) dut (
      .clk(clk), .reset(reset), .cen(cen), .wrMode(wrMode),
      .dataWr(dataWr), .dataIn(dataIn), .bufEmpty(bufEmpty),
      .writeUnderrun_n(writeUnderrun_n), .wrStream(wrStream),
      .byteDone(byteDone), .byteOut(byteOut)
   );

   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;
   int cyc = 0;
   int tog = 0;
   bit prev_ws = 1'b0;
   bit got_done = 1'b0;
   int done_cyc = 0;
   logic [7:0] done_val = 8'd0;

   // Model: a byte occupies cnt = 0 .. 8N-1 ticks; bit (7 - cnt/N) is emitted when cnt%N == 0.
   bit m_busy, m_under, m_full, m_ws, m_done, m_une;
   logic [7:0] m_buf, m_byte, m_out;
   int m_cnt;

   function automatic void start(input logic [7:0] b);
      m_byte = b;
      m_cnt  = 0;
      m_busy = 1'b1;
      if (b[7]) m_ws = !m_ws;
   endfunction

   function automatic void model_step();
      bit acc, pf, used;
      logic [7:0] pb;
      logic [7:0] cur;
      if (reset) begin
         m_busy = 0; m_under = 0; m_full = 0; m_ws = 0; m_done = 0;
         m_une = 1; m_buf = 0; m_byte = 0; m_out = 0; m_cnt = 0;
      end else if (!wrMode) begin
         m_busy = 0; m_under = 0; m_full = 0; m_une = 1; m_done = 0;
      end else begin
         m_done = 0;
         acc  = dataWr && !m_full && !m_under;
         pf   = m_full || acc;
         pb   = m_full ? m_buf : dataIn;
         used = 0;
         if (cen) begin
            if (m_busy) begin
               m_cnt++;
               if (m_cnt == 8 * N) begin
                  m_done = 1;
                  m_out  = m_byte;
                  if (pf) begin
                     start(pb);
                     used = 1;
                  end else begin
                     m_busy = 0; m_under = 1; m_une = 0;
                  end
               end else if (m_cnt % N == 0) begin
                  cur = m_byte;
                  if (cur[7 - m_cnt / N]) m_ws = !m_ws;
               end
            end else if (!m_under && m_full) begin
               start(m_buf);
               used = 1;
            end
         end
         m_full = pf && !used;
         if (pf) m_buf = pb;
      end
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      model_step();
      chk("model", {bufEmpty, writeUnderrun_n, wrStream, byteDone, byteOut},
          {!m_full, m_une, m_ws, m_done, m_out});
      if (wrStream !== prev_ws) tog++;
      prev_ws = wrStream;
      if (byteDone === 1'b1) begin
         got_done = 1;
         done_cyc = cyc;
         done_val = byteOut;
      end
   endtask

   task automatic wr(input logic [7:0] d);
      dataWr = 1; dataIn = d;
      tick();
      dataWr = 0;
   endtask

   task automatic wait_done(output int c, output logic [7:0] v);
      int k;
      got_done = 0;
      k = 0;
      while (!got_done && k < 80) begin
         tick();
         k++;
      end
      chk("done_seen", got_done, 1);
      c = done_cyc;
      v = done_val;
   endtask

   task automatic fresh();
      wrMode = 0; tick();
      wrMode = 1; tick();
   endtask

   typedef struct {
      logic [7:0] d;
      int         toggles;
   } vec_t;

   vec_t vt[5];

   initial begin
      int c1, c2, ld, t0;
      logic [7:0] v1, v2;
      bit w0;
      reset = 1; cen = 1; wrMode = 0; dataWr = 0; dataIn = 0;
      tick();
      reset = 0;
      chk("rst_bufEmpty", bufEmpty, 1);
      chk("rst_une", writeUnderrun_n, 1);
      chk("rst_ws", wrStream, 0);
      chk("rst_out", byteOut, 0);

      vt[0] = '{8'hFF, 8};
      vt[1] = '{8'hD5, 5};
      vt[2] = '{8'h00, 0};
      vt[3] = '{8'h81, 2};
      vt[4] = '{8'h3C, 4};
      foreach (vt[i]) begin
         fresh();
         tog = 0;
         wr(vt[i].d);
         chk("full_after_wr", bufEmpty, 0);
         tick();
         ld = cyc;
         chk("empty_after_load", bufEmpty, 1);
         wait_done(c1, v1);
         chk("byte_time", c1 - ld, 32);
         chk("byteOut", v1, vt[i].d);
         chk("toggles", tog, vt[i].toggles);
         repeat (8) tick();
         chk("underrun", writeUnderrun_n, 0);
         chk("no_more_toggles", tog, vt[i].toggles);
      end

      // back-to-back with the second byte written mid-shift
      fresh();
      tog = 0;
      wr(8'hD5);
      repeat (11) tick();
      wr(8'hAA);
      wait_done(c1, v1);
      chk("b2b_first", v1, 8'hD5);
      tick();
      chk("b2b_no_underrun", writeUnderrun_n, 1);
      wait_done(c2, v2);
      chk("b2b_second", v2, 8'hAA);
      chk("b2b_spacing", c2 - c1, 32);
      chk("b2b_toggles", tog, 9);
      tick();
      chk("b2b_underrun", writeUnderrun_n, 0);

      // write while full: 0x3C must be dropped
      fresh();
      wr(8'h00);
      repeat (4) tick();
      wr(8'h96);
      tick();
      wr(8'h3C);
      wait_done(c1, v1);
      chk("wf_first", v1, 8'h00);
      wait_done(c2, v2);
      chk("wf_second", v2, 8'h96);
      tick();
      chk("wf_underrun", writeUnderrun_n, 0);

      // write landing exactly on the boundary cycle
      fresh();
      wr(8'h00);
      repeat (32) tick();
      wr(8'h81);
      chk("race_done", byteDone, 1);
      chk("race_une", writeUnderrun_n, 1);
      c1 = cyc;
      wait_done(c2, v2);
      chk("race_byte", v2, 8'h81);
      chk("race_spacing", c2 - c1, 32);

      // abort around bit 3 of 0xAA with a byte buffered
      fresh();
      wr(8'hAA);
      tick();
      wr(8'h55);
      repeat (15) tick();
      w0 = wrStream;
      got_done = 0;
      wrMode = 0;
      tick();
      chk("abort_empty", bufEmpty, 1);
      chk("abort_une", writeUnderrun_n, 1);
      chk("abort_ws", wrStream, w0);
      repeat (40) tick();
      chk("abort_no_done", got_done, 0);
      wrMode = 1;
      tog = 0;
      repeat (10) tick();
      chk("reenter_idle", tog, 0);
      chk("reenter_empty", bufEmpty, 1);

      // abort while in underrun
      wr(8'hAA);
      wait_done(c1, v1);
      tick();
      chk("ur_une", writeUnderrun_n, 0);
      wrMode = 0;
      tick();
      chk("ur_abort_une", writeUnderrun_n, 1);
      wrMode = 1;

      // reset in mid-shift with wrStream high
      fresh();
      wr(8'hFF);
      c1 = 0;
      while (wrStream !== 1'b1 && c1 < 40) begin
         tick();
         c1++;
      end
      chk("rst_pre_ws", wrStream, 1);
      reset = 1;
      tick();
      reset = 0;
      chk("rst2_ws", wrStream, 0);
      chk("rst2_empty", bufEmpty, 1);
      chk("rst2_une", writeUnderrun_n, 1);
      chk("rst2_done", byteDone, 0);
      chk("rst2_out", byteOut, 0);

      // randomized run
      t0 = 0;
      wrMode = 1;
      repeat (3000) begin
         cen    = ($urandom % 3) != 0;
         dataWr = ($urandom % 6) == 0;
         dataIn = 8'($urandom);
         if ($urandom % 150 == 0) wrMode = !wrMode;
         reset  = ($urandom % 700) == 0;
         tick();
         t0++;
      end
      reset = 0; dataWr = 0; cen = 1;
      tick();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
